// File: rtl/minimig_autoconfig_master.sv
// Host-side AutoConfig initiator: walks the Zorro chain at $E80000, sizes each board,
// assigns it a naturally aligned base from the ZII or ZIII pool, or shuts it up.
`timescale 1ns/1ps
module minimig_autoconfig_master #(
  parameter int unsigned MAX_BOARDS     = 8,
  parameter logic [7:0]  ZII_POOL_BASE  = 8'h20,
  parameter logic [7:0]  ZII_POOL_END   = 8'hA0,
  parameter logic [15:0] ZIII_POOL_BASE = 16'h4000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk7_en,
  input  logic        start,
  output logic        bus_req,
  input  logic        bus_ack,
  output logic [7:0]  address_out,
  output logic        rd,
  output logic        hwr,
  output logic        lwr,
  output logic [15:0] data_out,
  input  logic [15:0] data_in,
  output logic [3:0]  board_count,
  output logic [3:0]  shutup_count,
  output logic [7:0]  zii_next,
  output logic [15:0] ziii_next,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE, RD_T0, RD_T1, RD_F0, DECODE, WR_BASE, WR_SHUT, NEXT, DONE
  } state_t;

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d, rd_q, rd_d, hwr_q, hwr_d, lwr_q, lwr_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  bcnt_q, bcnt_d, scnt_q, scnt_d;
  logic [7:0]  zii_q, zii_d;
  logic [15:0] ziii_q, ziii_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [7:0]  type_q, type_d;
  logic        ext_q, ext_d;
  logic        z3_q, z3_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] nptr_q, nptr_d;

  logic [2:0]  code;
  logic        zorro3, reserved, fits;
  logic [17:0] size_u, cur, base, sum;

  logic unused_bits;
  assign unused_bits = ^{data_in[11:0], type_q[5:3]};

  // Sizes and addresses are in 64K units; 18 bits keeps the ZIII end-of-space carry visible.
  always_comb begin
    code     = type_q[2:0];
    zorro3   = (type_q[7:6] == 2'b10);
    size_u   = '0;
    reserved = 1'b0;
    if (zorro3 && ext_q) begin
      if (code == 3'b111) reserved = 1'b1;
      else                size_u   = 18'h100 << code;
    end else if (code == 3'b000) begin
      size_u = 18'h80;
    end else begin
      size_u = 18'h1 << (code - 3'd1);
    end
    cur  = zorro3 ? {2'b00, ziii_q} : {10'b0, zii_q};
    base = (cur + size_u - 18'd1) & ~(size_u - 18'd1);
    sum  = base + size_u;
    fits = !reserved && (zorro3 ? (sum <= 18'h0FFFF) : (sum <= {10'b0, ZII_POOL_END}));
  end

  always_comb begin
    state_d   = state_q;
    bus_req_d = bus_req_q;
    rd_d      = rd_q;
    hwr_d     = hwr_q;
    lwr_d     = lwr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    bcnt_d    = bcnt_q;
    scnt_d    = scnt_q;
    zii_d     = zii_q;
    ziii_d    = ziii_q;
    busy_d    = busy_q;
    done_d    = done_q;
    type_d    = type_q;
    ext_d     = ext_q;
    z3_d      = z3_q;
    wdata_d   = wdata_q;
    nptr_d    = nptr_q;
    if (clk7_en) begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            bcnt_d  = '0;
            scnt_d  = '0;
            zii_d   = ZII_POOL_BASE;
            ziii_d  = ZIII_POOL_BASE;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            state_d = RD_T0;
          end
        end
        RD_T0, RD_T1, RD_F0: begin
          if (!bus_req_q) begin
            bus_req_d = 1'b1;
            rd_d      = 1'b1;
            addr_d    = (state_q == RD_T0) ? 8'h00 : (state_q == RD_T1) ? 8'h01 : 8'h04;
          end else if (bus_ack) begin
            bus_req_d = 1'b0;
            rd_d      = 1'b0;
            if (state_q == RD_T0) begin
              type_d[7:4] = data_in[15:12];
              state_d     = RD_T1;
            end else if (state_q == RD_T1) begin
              type_d[3:0] = data_in[15:12];
              state_d     = RD_F0;
            end else begin
              // flag nibble reads back inverted, so er_Flags bit 5 is the raw bit 1 negated
              ext_d   = ~data_in[13];
              state_d = DECODE;
            end
          end
        end
        DECODE: begin
          if (!type_q[7]) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (fits) begin
            z3_d    = zorro3;
            wdata_d = zorro3 ? base[15:0] : {base[7:0], base[7:0]};
            nptr_d  = sum[15:0];
            state_d = WR_BASE;
          end else begin
            state_d = WR_SHUT;
          end
        end
        WR_BASE, WR_SHUT: begin
          if (!bus_req_q) begin
            bus_req_d = 1'b1;
            hwr_d     = 1'b1;
            lwr_d     = 1'b1;
            if (state_q == WR_SHUT) begin
              addr_d = 8'h26;
              data_d = '0;
            end else begin
              addr_d = z3_q ? 8'h22 : 8'h24;
              data_d = wdata_q;
            end
          end else if (bus_ack) begin
            bus_req_d = 1'b0;
            hwr_d     = 1'b0;
            lwr_d     = 1'b0;
            state_d   = NEXT;
            if (state_q == WR_SHUT) begin
              scnt_d = scnt_q + 4'd1;
            end else begin
              bcnt_d = bcnt_q + 4'd1;
              if (z3_q) ziii_d = nptr_q;
              else      zii_d  = nptr_q[7:0];
            end
          end
        end
        NEXT: begin
          if (({1'b0, bcnt_q} + {1'b0, scnt_q}) == 5'(MAX_BOARDS)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = RD_T0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bus_req_q <= 1'b0;
      rd_q      <= 1'b0;
      hwr_q     <= 1'b0;
      lwr_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      bcnt_q    <= '0;
      scnt_q    <= '0;
      zii_q     <= ZII_POOL_BASE;
      ziii_q    <= ZIII_POOL_BASE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      type_q    <= '0;
      ext_q     <= 1'b0;
      z3_q      <= 1'b0;
      wdata_q   <= '0;
      nptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      bus_req_q <= bus_req_d;
      rd_q      <= rd_d;
      hwr_q     <= hwr_d;
      lwr_q     <= lwr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      bcnt_q    <= bcnt_d;
      scnt_q    <= scnt_d;
      zii_q     <= zii_d;
      ziii_q    <= ziii_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      type_q    <= type_d;
      ext_q     <= ext_d;
      z3_q      <= z3_d;
      wdata_q   <= wdata_d;
      nptr_q    <= nptr_d;
    end
  end

  assign bus_req      = bus_req_q;
  assign rd           = rd_q;
  assign hwr          = hwr_q;
  assign lwr          = lwr_q;
  assign address_out  = addr_q;
  assign data_out     = data_q;
  assign board_count  = bcnt_q;
  assign shutup_count = scnt_q;
  assign zii_next     = zii_q;
  assign ziii_next    = ziii_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_minimig_autoconfig_master.sv
// Scoreboarded bench: a board-chain responder answers bus cycles, a reference walk fills the
// expected transaction/result queues, and a monitor pops them as the DUT completes cycles.
`timescale 1ns/1ps
module tb_minimig_autoconfig_master;

  typedef struct packed {
    logic [7:0]  addr;
    logic        rd, hwr, lwr;
    logic [15:0] data;
  } txn_t;

  typedef struct packed {
    logic [3:0]  bc, sc;
    logic [7:0]  zii;
    logic [15:0] z3;
  } fin_t;

  logic clk = 1'b0;
  logic reset_n, clk7_en, start, bus_ack, sel;
  logic [15:0] data_in;

  logic start_a, start_b, ack_a, ack_b;
  logic req_a, rd_a, hwr_a, lwr_a, busy_a, done_a;
  logic req_b, rd_b, hwr_b, lwr_b, busy_b, done_b;
  logic [7:0]  addr_a, zii_a, addr_b, zii_b;
  logic [15:0] dout_a, z3_a, dout_b, z3_b;
  logic [3:0]  bc_a, sc_a, bc_b, sc_b;

  logic m_req, m_rd, m_hwr, m_lwr, m_busy, m_done;
  logic [7:0]  m_addr, m_zii;
  logic [15:0] m_data, m_z3;
  logic [3:0]  m_bc, m_sc;

  txn_t exp_q[$];
  fin_t fin_q[$];
  int   checks = 0, errors = 0;
  int   walk_id = 0;
  bit   stall_rd1 = 0, stall_wr = 0;
  logic [7:0] bt[16];
  logic [3:0] bf[16];
  int   bn = 0;

  always #5 clk = ~clk;

  assign start_a = start && !sel;
  assign start_b = start && sel;
  assign ack_a   = bus_ack && !sel;
  assign ack_b   = bus_ack && sel;

  minimig_autoconfig_master dut_a (
    .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en), .start(start_a),
    .bus_req(req_a), .bus_ack(ack_a), .address_out(addr_a), .rd(rd_a), .hwr(hwr_a), .lwr(lwr_a),
    .data_out(dout_a), .data_in(data_in), .board_count(bc_a), .shutup_count(sc_a),
    .zii_next(zii_a), .ziii_next(z3_a), .busy(busy_a), .done(done_a));

  minimig_autoconfig_master #(.MAX_BOARDS(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en), .start(start_b),
    .bus_req(req_b), .bus_ack(ack_b), .address_out(addr_b), .rd(rd_b), .hwr(hwr_b), .lwr(lwr_b),
    .data_out(dout_b), .data_in(data_in), .board_count(bc_b), .shutup_count(sc_b),
    .zii_next(zii_b), .ziii_next(z3_b), .busy(busy_b), .done(done_b));

  assign m_req  = sel ? req_b  : req_a;
  assign m_rd   = sel ? rd_b   : rd_a;
  assign m_hwr  = sel ? hwr_b  : hwr_a;
  assign m_lwr  = sel ? lwr_b  : lwr_a;
  assign m_addr = sel ? addr_b : addr_a;
  assign m_data = sel ? dout_b : dout_a;
  assign m_bc   = sel ? bc_b   : bc_a;
  assign m_sc   = sel ? sc_b   : sc_a;
  assign m_zii  = sel ? zii_b  : zii_a;
  assign m_z3   = sel ? z3_b   : z3_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;

  function automatic logic [3:0] reg_nib(input int idx, input logic [7:0] a);
    if (idx >= bn) return 4'h0;
    case (a)
      8'h00:   return bt[idx][7:4];
      8'h01:   return bt[idx][3:0];
      8'h04:   return bf[idx];
      default: return 4'h0;
    endcase
  endfunction

  // Board chain: the first unconfigured board answers; any write moves the chain on.
  initial begin : responder
    int cnt, lim, seen, ridx;
    bit was_wr;
    bus_ack = 1'b0; data_in = '0; clk7_en = 1'b0;
    cnt = 0; lim = 1; seen = 0; ridx = 0; was_wr = 0;
    forever begin
      @(negedge clk);
      clk7_en = ($urandom_range(0, 3) != 0);
      if (bus_ack && !m_req) begin
        bus_ack = 1'b0;
        if (was_wr) ridx++;
      end
      if (seen != walk_id) begin
        seen = walk_id;
        ridx = 0;
      end
      if (!m_req) begin
        cnt = 0;
      end else if (!bus_ack) begin
        if (cnt == 0) lim = (stall_rd1 && m_rd && m_addr == 8'h01) ? 20 : $urandom_range(0, 3);
        cnt++;
        if (cnt > lim && !(stall_wr && (m_hwr || m_lwr))) begin
          bus_ack = 1'b1;
          was_wr  = m_hwr || m_lwr;
          data_in = {reg_nib(ridx, m_addr), 12'($urandom)};
        end else begin
          data_in = 16'($urandom);
        end
      end
    end
  end

  initial begin : monitor
    logic [7:0]  sa;
    logic [2:0]  ss;
    logic [15:0] sd;
    bit stable, prev_req, prev_done, prev_sel;
    txn_t e, act;
    fin_t f, fa;
    stable = 1; prev_req = 0; prev_done = 0; prev_sel = 0;
    sa = '0; ss = '0; sd = '0;
    forever begin
      @(negedge clk); #1;
      if (m_req && !prev_req) begin
        sa = m_addr; ss = {m_rd, m_hwr, m_lwr}; sd = m_data; stable = 1;
      end else if (m_req && (sa !== m_addr || ss !== {m_rd, m_hwr, m_lwr} || sd !== m_data)) begin
        stable = 0;
      end
      if (m_req && bus_ack && clk7_en) begin
        act = '{addr: m_addr, rd: m_rd, hwr: m_hwr, lwr: m_lwr, data: (m_rd ? 16'h0 : m_data)};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL txn_unexpected got=%h", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL txn got addr=%h rd=%b hwr=%b lwr=%b data=%h want addr=%h rd=%b hwr=%b lwr=%b data=%h",
                     act.addr, act.rd, act.hwr, act.lwr, act.data, e.addr, e.rd, e.hwr, e.lwr, e.data);
          end
        end
        checks++;
        if (!stable) begin
          errors++;
          $display("FAIL hold_stable got=0 want=1 addr=%h", m_addr);
        end
      end
      if (m_done && !prev_done && sel == prev_sel) begin
        checks++;
        if (fin_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected");
        end else begin
          f  = fin_q.pop_front();
          fa = '{bc: m_bc, sc: m_sc, zii: m_zii, z3: m_z3};
          if (fa !== f || m_busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL walk_result got bc=%0d sc=%0d zii=%h z3=%h busy=%b pend=%0d want bc=%0d sc=%0d zii=%h z3=%h busy=0 pend=0",
                     fa.bc, fa.sc, fa.zii, fa.z3, m_busy, exp_q.size(), f.bc, f.sc, f.zii, f.z3);
          end
        end
        exp_q.delete();
      end
      prev_req = m_req; prev_done = m_done; prev_sel = sel;
    end
  end

  function automatic txn_t rd_txn(input logic [7:0] a);
    return '{addr: a, rd: 1'b1, hwr: 1'b0, lwr: 1'b0, data: 16'h0};
  endfunction

  function automatic txn_t wr_txn(input logic [7:0] a, input logic [15:0] d);
    return '{addr: a, rd: 1'b0, hwr: 1'b1, lwr: 1'b1, data: d};
  endfunction

  // Reference walk in byte-free 64K units: round up with division, compare against pool limits.
  task automatic build_expect(input int maxb);
    int zii, z3, bc, sc, u, code, bas;
    bit isz3, ok;
    logic [7:0] t;
    logic [3:0] fl;
    logic [15:0] b16;
    zii = 32; z3 = 16'h4000; bc = 0; sc = 0;
    for (int i = 0; i < 16; i++) begin
      t  = (i < bn) ? bt[i] : 8'h00;
      fl = (i < bn) ? bf[i] : 4'h0;
      exp_q.push_back(rd_txn(8'h00));
      exp_q.push_back(rd_txn(8'h01));
      exp_q.push_back(rd_txn(8'h04));
      if (t[7] == 1'b0) break;
      isz3 = (t[7:6] == 2'b10);
      code = int'(t[2:0]);
      if (isz3 && !fl[1]) u = (code == 7) ? 0 : (256 << code);
      else                u = (code == 0) ? 128 : (1 << (code - 1));
      ok = 0; bas = 0;
      if (u != 0) begin
        bas = isz3 ? ((z3 + u - 1) / u) * u : ((zii + u - 1) / u) * u;
        ok  = isz3 ? (bas + u <= 65535) : (bas + u <= 160);
      end
      b16 = 16'(bas);
      if (ok) begin
        exp_q.push_back(isz3 ? wr_txn(8'h22, b16) : wr_txn(8'h24, {b16[7:0], b16[7:0]}));
        if (isz3) z3 = bas + u; else zii = bas + u;
        bc++;
      end else begin
        exp_q.push_back(wr_txn(8'h26, 16'h0));
        sc++;
      end
      if (bc + sc == maxb) break;
    end
    fin_q.push_back('{bc: 4'(bc), sc: 4'(sc), zii: 8'(zii), z3: 16'(z3)});
  endtask

  task automatic load(input int n, input logic [31:0] ty, input logic [15:0] fl);
    bn = n;
    for (int i = 0; i < 16; i++) begin
      bt[i] = 8'h00; bf[i] = 4'h0;
      if (i < 4) begin
        bt[i] = ty[8*i +: 8];
        bf[i] = fl[4*i +: 4];
      end
    end
  endtask

  task automatic pulse_start();
    int k;
    @(negedge clk); #1 start = 1'b1;
    k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (!clk7_en && k < 100);
    #1 start = 1'b0;
  endtask

  task automatic run_walk(input bit use_b);
    bit got;
    sel = use_b;
    build_expect(use_b ? 2 : 8);
    walk_id++;
    pulse_start();
    got = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk); #2;
      if (m_done) begin got = 1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL walk_timeout done=%b busy=%b want done=1", m_done, m_busy);
      exp_q.delete(); fin_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset(input string nm);
    logic [45:0] got, want;
    got  = {m_req, m_rd, m_hwr, m_lwr, m_addr, m_data, m_bc, m_sc, m_zii, m_z3, m_busy, m_done};
    want = {4'b0, 8'h00, 16'h0000, 4'h0, 4'h0, 8'h20, 16'h4000, 2'b00};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL global_timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit seen_wr;
    reset_n = 1'b0; start = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset("reset_state");
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(negedge clk);

    load(1, 32'h000000E7, 16'h0000); run_walk(0);         // ZII 4M
    load(2, 32'h0000E0E1, 16'h0000); run_walk(0);         // 64K then 8M (shut up)
    load(2, 32'h0000A0A2, 16'h00DD); run_walk(0);         // ZIII 64M then 16M
    load(2, 32'h0000A5A7, 16'h00FD); run_walk(0);         // reserved ext size, then ZIII w/o ext
    load(3, 32'h00E1E6E7, 16'h0000); run_walk(0);         // exact fit to pool end, then overflow
    load(3, 32'h00E3E2E1, 16'h0000); run_walk(1);         // MAX_BOARDS=2 stops before board 3

    // long ack stall on the second type read, with a start pulse that must be ignored
    load(1, 32'h000000E7, 16'h0000);
    stall_rd1 = 1;
    fork
      run_walk(0);
      begin
        for (int k = 0; k < 300; k++) begin
          @(negedge clk); #2;
          if (m_req && m_rd && m_addr == 8'h01) break;
        end
        repeat (3) @(negedge clk);
        pulse_start();
      end
    join
    stall_rd1 = 0;

    // reset while a base write waits for its ack
    load(1, 32'h000000E1, 16'h0000);
    sel = 0; stall_wr = 1;
    exp_q.push_back(rd_txn(8'h00));
    exp_q.push_back(rd_txn(8'h01));
    exp_q.push_back(rd_txn(8'h04));
    walk_id++;
    pulse_start();
    seen_wr = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk); #2;
      if (m_req && m_hwr) begin seen_wr = 1; break; end
    end
    checks++;
    if (!seen_wr || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wr_wait got seen=%b pend=%0d want seen=1 pend=0", seen_wr, exp_q.size());
    end
    exp_q.delete();
    @(negedge clk) reset_n = 1'b0;
    @(posedge clk);
    #1 check_reset("reset_mid_write");
    @(negedge clk) reset_n = 1'b1;
    stall_wr = 0;
    run_walk(0);

    for (int w = 0; w < 24; w++) begin
      bn = $urandom_range(0, 10);
      for (int i = 0; i < 16; i++) begin
        bt[i] = 8'($urandom);
        if ($urandom_range(0, 11) != 0) bt[i][7] = 1'b1;
        bf[i] = 4'($urandom);
      end
      run_walk($urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
